// File: rtl/stopwatch_core.sv
// stopwatch_core: debounces the three buttons, runs the start/pause/lap/clear control and keeps
// elapsed time as BCD SS.hh. Digit, dot and running outputs are registered for the display driver.
module stopwatch_core #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned TICK_HZ         = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C,
  output logic [3:0] D,
  output logic [0:3] dots,
  output logic       running
);

  localparam int unsigned Div = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [PW-1:0]  PrescMax = PW'(Div - 1);
  localparam logic [DbW-1:0] DbMax    = DbW'(DEBOUNCE_CYCLES);

  localparam int unsigned BtnStart = 0;
  localparam int unsigned BtnLap   = 1;
  localparam int unsigned BtnClear = 2;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StLap,
    StPause,
    StFull
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // Button path: 2-flop synchronizer, stability counter, rising-edge pulse.
  // ---------------------------------------------------------------------------------------------
  logic [2:0]     raw;
  logic [2:0]     sync1_q;
  logic [2:0]     sync2_q;
  logic [2:0]     level_q;
  logic [2:0]     level_prev_q;
  logic [2:0]     pulse;
  logic [DbW-1:0] stable_cnt_q [3];

  assign raw = {btn_clear, btn_lap, btn_start};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      for (int i = 0; i < 3; i++) begin
        stable_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          stable_cnt_q[i] <= '0;
        end else if (stable_cnt_q[i] == DbMax) begin
          level_q[i]      <= sync2_q[i];
          stable_cnt_q[i] <= '0;
        end else begin
          stable_cnt_q[i] <= stable_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign pulse = level_q & ~level_prev_q;

  // Only the highest-priority pulse survives: clear, then start, then lap.
  logic ev_clear;
  logic ev_start;
  logic ev_lap;

  assign ev_clear = pulse[BtnClear];
  assign ev_start = pulse[BtnStart] & ~pulse[BtnClear];
  assign ev_lap   = pulse[BtnLap] & ~pulse[BtnStart] & ~pulse[BtnClear];

  // ---------------------------------------------------------------------------------------------
  // Timekeeping
  // ---------------------------------------------------------------------------------------------
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [15:0]   count_q;
  logic [15:0]   hold_q;
  logic [15:0]   count_inc;
  logic          counting;
  logic          tick;
  logic          reach_full;

  assign counting   = (state_q == StRun) || (state_q == StLap);
  assign tick       = counting && (presc_q == PrescMax);
  assign count_inc  = bcd_inc(count_q);
  assign reach_full = tick && (count_inc == 16'h9999);

  // ---------------------------------------------------------------------------------------------
  // Control FSM with registered display outputs
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      presc_q <= '0;
      count_q <= '0;
      hold_q  <= '0;
      A       <= 4'd0;
      B       <= 4'd0;
      C       <= 4'd0;
      D       <= 4'd0;
      dots    <= 4'b0100;
      running <= 1'b0;
    end else begin
      // A tick on the edge that leaves RUN/LAP is still counted.
      if (counting) begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          count_q <= count_inc;
        end
      end

      case (state_q)
        StIdle: begin
          if (ev_start) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (reach_full) begin
            state_q <= StFull;
          end else if (ev_start) begin
            state_q <= StPause;
          end else if (ev_lap) begin
            state_q <= StLap;
            hold_q  <= count_q;
          end
        end
        StLap: begin
          if (reach_full) begin
            state_q <= StFull;
          end else if (ev_start) begin
            state_q <= StPause;
          end else if (ev_lap) begin
            state_q <= StRun;
          end
        end
        StPause: begin
          if (ev_clear) begin
            state_q <= StIdle;
            presc_q <= '0;
            count_q <= '0;
          end else if (ev_start) begin
            state_q <= StRun;
          end
        end
        StFull: begin
          if (ev_clear) begin
            state_q <= StIdle;
            presc_q <= '0;
            count_q <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      if (state_q == StLap) begin
        {A, B, C, D} <= hold_q;
      end else begin
        {A, B, C, D} <= count_q;
      end

      case (state_q)
        StLap:   dots <= 4'b0101;
        StFull:  dots <= 4'b1111;
        default: dots <= 4'b0100;
      endcase

      running <= counting;
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Testbench for stopwatch_core: scenario tasks plus randomized presses, checked against a
// hundredths-counting reference model; a fast-tick second instance covers saturation.
module tb_stopwatch_core;

  localparam int unsigned ClkHz  = 1000;
  localparam int unsigned TickHz = 100;
  localparam int unsigned Deb    = 4;
  localparam int          Div    = ClkHz / TickHz;

  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MLap   = 2;
  localparam int MPause = 3;
  localparam int MFull  = 4;

  localparam logic [20:0] IdleOut = {16'h0000, 4'b0100, 1'b0};
  localparam logic [20:0] FullOut = {16'h9999, 4'b1111, 1'b0};

  logic clk = 1'b0;
  logic rst;
  logic btn_start, btn_lap, btn_clear;
  logic [3:0] A, B, C, D;
  logic [0:3] dots;
  logic running;

  logic s2_start, s2_lap, s2_clear;
  logic [3:0] A2, B2, C2, D2;
  logic [0:3] dots2;
  logic running2;

  logic [20:0] dut_out;
  logic [20:0] dut2_out;
  assign dut_out  = {A, B, C, D, dots, running};
  assign dut2_out = {A2, B2, C2, D2, dots2, running2};

  always #5 clk = ~clk;

  stopwatch_core #(
    .CLK_HZ(ClkHz),
    .TICK_HZ(TickHz),
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_start(btn_start),
    .btn_lap(btn_lap),
    .btn_clear(btn_clear),
    .A(A),
    .B(B),
    .C(C),
    .D(D),
    .dots(dots),
    .running(running)
  );

  // Two clocks per hundredth so 99.99 is reachable in a short run.
  stopwatch_core #(
    .CLK_HZ(200),
    .TICK_HZ(100),
    .DEBOUNCE_CYCLES(2)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .btn_start(s2_start),
    .btn_lap(s2_lap),
    .btn_clear(s2_clear),
    .A(A2),
    .B(B2),
    .C(C2),
    .D(D2),
    .dots(dots2),
    .running(running2)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: elapsed time as an integer number of hundredths.
  int          m_st, m_cnt, m_hold, m_presc;
  logic [2:0]  m_db, m_pend;
  logic [31:0] m_hist [3];
  logic [20:0] exp_out;

  function automatic logic [15:0] to_bcd(input int v);
    logic [3:0] a, b, c, d;
    a = 4'(v / 1000);
    b = 4'((v / 100) % 10);
    c = 4'((v / 10) % 10);
    d = 4'(v % 10);
    return {a, b, c, d};
  endfunction

  function automatic logic [20:0] model_out(input int st, input int cnt, input int hold);
    logic [3:0] dt;
    logic       r;
    dt = (st == MLap) ? 4'b0101 : (st == MFull) ? 4'b1111 : 4'b0100;
    r  = (st == MRun) || (st == MLap);
    return {to_bcd((st == MLap) ? hold : cnt), dt, r};
  endfunction

  // Advance one clock: sample inputs at the edge, update the model, return 1 time unit later.
  task automatic step();
    logic [2:0] raw;
    logic       tick, ok;
    int         old, ev;
    @(posedge clk);
    raw = {btn_clear, btn_lap, btn_start};
    if (rst) begin
      m_st    = MIdle;
      m_cnt   = 0;
      m_hold  = 0;
      m_presc = 0;
      m_db    = '0;
      m_pend  = '0;
      for (int b = 0; b < 3; b++) m_hist[b] = '0;
      exp_out = IdleOut;
    end else begin
      exp_out = model_out(m_st, m_cnt, m_hold);
      ev = m_pend[2] ? 3 : m_pend[0] ? 1 : m_pend[1] ? 2 : 0;
      tick = ((m_st == MRun) || (m_st == MLap)) && (m_presc == Div - 1);
      old  = m_cnt;
      if ((m_st == MRun) || (m_st == MLap)) begin
        m_presc = tick ? 0 : m_presc + 1;
        if (tick) m_cnt = m_cnt + 1;
      end
      case (m_st)
        MIdle: if (ev == 1) m_st = MRun;
        MRun: begin
          if (tick && m_cnt == 9999) m_st = MFull;
          else if (ev == 1) m_st = MPause;
          else if (ev == 2) begin
            m_st   = MLap;
            m_hold = old;
          end
        end
        MLap: begin
          if (tick && m_cnt == 9999) m_st = MFull;
          else if (ev == 1) m_st = MPause;
          else if (ev == 2) m_st = MRun;
        end
        MPause: begin
          if (ev == 3) begin
            m_st    = MIdle;
            m_cnt   = 0;
            m_presc = 0;
          end else if (ev == 1) m_st = MRun;
        end
        default: begin
          if (ev == 3) begin
            m_st    = MIdle;
            m_cnt   = 0;
            m_presc = 0;
          end
        end
      endcase
      // Level flips once the last Deb+1 synchronized samples all disagree with it.
      for (int b = 0; b < 3; b++) begin
        ok = 1'b1;
        for (int j = 1; j <= Deb + 1; j++) if (m_hist[b][j] == m_db[b]) ok = 1'b0;
        m_pend[b] = 1'b0;
        if (ok) begin
          m_db[b]   = ~m_db[b];
          m_pend[b] = m_db[b];
        end
        m_hist[b] = {m_hist[b][30:0], raw[b]};
      end
    end
    #1;
  endtask

  task automatic test_reset();
    {btn_clear, btn_lap, btn_start} = 3'b000;
    rst = 1'b1;
    step();
    step();
    n_vec++;
    if (dut_out !== IdleOut) begin
      n_miss++;
      $display("FAIL reset_state: got %h expected %h", dut_out, IdleOut);
    end
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      btn_start = (i < 8);
      step();
      n_vec++;
      if (dut_out !== exp_out) begin
        n_miss++;
        $display("FAIL reset_prerun cyc %0d: got %h expected %h", i, dut_out, exp_out);
      end
    end
    n_vec++;
    if (running !== 1'b1) begin
      n_miss++;
      $display("FAIL reset_prerun_running: got %b expected 1", running);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (dut_out !== IdleOut) begin
      n_miss++;
      $display("FAIL reset_mid_run: got %h expected %h", dut_out, IdleOut);
    end
    for (int i = 0; i < 100; i++) begin
      step();
      n_vec++;
      if (dut_out !== IdleOut || dut_out !== exp_out) begin
        n_miss++;
        $display("FAIL reset_hold cyc %0d: got %h expected %h", i, dut_out, IdleOut);
      end
    end
  endtask

  task automatic test_start_latency();
    int val;
    rst = 1'b1;
    step();
    rst = 1'b0;
    btn_start = 1'b1;
    for (int e = 0; e < 12; e++) begin
      step();
      if (e == 9) btn_start = 1'b0;
      n_vec++;
      if (running !== (e >= 8)) begin
        n_miss++;
        $display("FAIL start_latency edge k+%0d: running %b expected %b", e, running, (e >= 8));
      end
      n_vec++;
      if (dut_out !== exp_out) begin
        n_miss++;
        $display("FAIL start_model edge k+%0d: got %h expected %h", e, dut_out, exp_out);
      end
    end
    for (int i = 0; i < 997; i++) begin
      step();
      n_vec++;
      if (dut_out !== exp_out) begin
        n_miss++;
        $display("FAIL tick_rate_model cyc %0d: got %h expected %h", i, dut_out, exp_out);
      end
    end
    val = int'(A) * 1000 + int'(B) * 100 + int'(C) * 10 + int'(D);
    n_vec++;
    if (val < 99 || val > 101) begin
      n_miss++;
      $display("FAIL tick_rate: got %0d hundredths expected 100 +-1", val);
    end
  endtask

  task automatic test_bounce();
    logic [2:0] mask [5];
    int         len  [5];
    logic       run  [5];
    int         gl, gap;
    mask = '{3'b001, 3'b100, 3'b001, 3'b000, 3'b100};
    len  = '{50, 20, 20, 100, 20};
    run  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int g = 0; g < 8; g++) begin
      gl  = $urandom_range(1, 3);
      gap = $urandom_range(1, 6);
      for (int i = 0; i < gl + gap; i++) begin
        btn_start = (i < gl);
        step();
        n_vec++;
        if (dut_out !== IdleOut || dut_out !== exp_out) begin
          n_miss++;
          $display("FAIL bounce glitch %0d: got %h expected %h", g, dut_out, IdleOut);
        end
      end
    end
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < len[p]; i++) begin
        {btn_clear, btn_lap, btn_start} = (i < 8) ? mask[p] : 3'b000;
        step();
        n_vec++;
        if (dut_out !== exp_out) begin
          n_miss++;
          $display("FAIL bounce_phase %0d cyc %0d: got %h expected %h", p, i, dut_out, exp_out);
        end
      end
      n_vec++;
      if (running !== run[p] || dots !== 4'b0100) begin
        n_miss++;
        $display("FAIL bounce_state %0d: running %b dots %b expected %b 0100", p, running, dots,
                 run[p]);
      end
    end
    n_vec++;
    if ({A, B, C, D} !== 16'h0000) begin
      n_miss++;
      $display("FAIL clear_to_idle: got %h expected 0000", {A, B, C, D});
    end
  endtask

  task automatic test_lap();
    int guard, val;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      btn_start = (i < 8);
      step();
      n_vec++;
      if (dut_out !== exp_out) begin
        n_miss++;
        $display("FAIL lap_start cyc %0d: got %h expected %h", i, dut_out, exp_out);
      end
    end
    guard = 0;
    while (m_cnt != 25 && guard < 400) begin
      step();
      guard++;
      n_vec++;
      if (dut_out !== exp_out) begin
        n_miss++;
        $display("FAIL lap_wait cyc %0d: got %h expected %h", guard, dut_out, exp_out);
      end
    end
    n_vec++;
    if (guard >= 400) begin
      n_miss++;
      $display("FAIL lap_wait_timeout: count %0d expected 25", m_cnt);
    end
    for (int i = 0; i < 500; i++) begin
      btn_lap = (i < 8);
      step();
      n_vec++;
      if (dut_out !== exp_out) begin
        n_miss++;
        $display("FAIL lap_hold cyc %0d: got %h expected %h", i, dut_out, exp_out);
      end
      if (i == 19 || i == 49) begin
        n_vec++;
        if ({A, B, C, D} !== 16'h0025 || dots !== 4'b0101 || running !== 1'b1) begin
          n_miss++;
          $display("FAIL lap_display cyc %0d: got %h dots %b expected 0025 0101", i,
                   {A, B, C, D}, dots);
        end
      end
    end
    for (int i = 0; i < 14; i++) begin
      btn_lap = (i < 8);
      step();
      n_vec++;
      if (dut_out !== exp_out) begin
        n_miss++;
        $display("FAIL lap_release cyc %0d: got %h expected %h", i, dut_out, exp_out);
      end
    end
    val = int'(A) * 1000 + int'(B) * 100 + int'(C) * 10 + int'(D);
    n_vec++;
    if (val < 74 || val > 78 || dots !== 4'b0100) begin
      n_miss++;
      $display("FAIL lap_live: got %0d dots %b expected about 75 dots 0100", val, dots);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] mask [5];
    int         len  [5];
    logic       run  [5];
    mask = '{3'b001, 3'b001, 3'b101, 3'b001, 3'b011};
    len  = '{14, 14, 14, 50, 14};
    run  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < len[p]; i++) begin
        {btn_clear, btn_lap, btn_start} = (i < 8) ? mask[p] : 3'b000;
        step();
        n_vec++;
        if (dut_out !== exp_out) begin
          n_miss++;
          $display("FAIL simul_phase %0d cyc %0d: got %h expected %h", p, i, dut_out, exp_out);
        end
      end
      n_vec++;
      if (running !== run[p] || dots !== 4'b0100) begin
        n_miss++;
        $display("FAIL simul_state %0d: running %b dots %b expected %b 0100", p, running, dots,
                 run[p]);
      end
      if (p == 2) begin
        n_vec++;
        if ({A, B, C, D} !== 16'h0000) begin
          n_miss++;
          $display("FAIL simul_clear: got %h expected 0000", {A, B, C, D});
        end
      end
    end
  endtask

  task automatic test_random();
    int         cyc, hold, gap;
    logic [2:0] mask;
    cyc = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    while (cyc < 3000) begin
      mask    = 3'($urandom_range(0, 3));
      mask[2] = ($urandom_range(0, 3) == 0);
      hold    = $urandom_range(1, 10);
      gap     = $urandom_range(1, 15);
      for (int i = 0; i < hold + gap; i++) begin
        {btn_clear, btn_lap, btn_start} = (i < hold) ? mask : 3'b000;
        rst = ($urandom_range(0, 499) == 0);
        step();
        cyc++;
        n_vec++;
        if (dut_out !== exp_out) begin
          n_miss++;
          $display("FAIL random cyc %0d: got %h expected %h", cyc, dut_out, exp_out);
        end
      end
    end
    rst = 1'b0;
    {btn_clear, btn_lap, btn_start} = 3'b000;
  endtask

  task automatic test_saturation();
    logic [20:0] exp2;
    int          n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    s2_start = 1'b1;
    for (int e = 0; e <= 22010; e++) begin
      step();
      if (e == 6) s2_start = 1'b0;
      if (e == 20100) s2_start = 1'b1;
      if (e == 20108) s2_start = 1'b0;
      if (e < 6) exp2 = IdleOut;
      else begin
        n    = (e - 6) / 2;
        exp2 = (n >= 9999) ? FullOut : {to_bcd(n), 4'b0100, 1'b1};
      end
      n_vec++;
      if (dut2_out !== exp2) begin
        n_miss++;
        $display("FAIL saturation edge k+%0d: got %h expected %h", e, dut2_out, exp2);
      end
    end
    s2_clear = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step();
      if (j == 6) s2_clear = 1'b0;
      exp2 = (j >= 6) ? IdleOut : FullOut;
      n_vec++;
      if (dut2_out !== exp2) begin
        n_miss++;
        $display("FAIL full_clear cyc %0d: got %h expected %h", j, dut2_out, exp2);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
    s2_start  = 1'b0;
    s2_lap    = 1'b0;
    s2_clear  = 1'b0;
    test_reset();
    test_start_latency();
    test_bounce();
    test_lap();
    test_simultaneous();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
